stage_wb_lq: RTL

Parametrised writeback stage for the pipelined RISC-V core with a load queue for variable-latency data memory. Non-load results (ALU, PC+4) retire immediately. Load metadata is queued until the matching in-order memory response arrives; the response is then aligned, sign- or zero-extended, and written back. A per-register pending scoreboard lets decode stall on read-after-write and write-after-write hazards against outstanding loads. The block sits between the execute/memory stage and the register file write port.

---
 rtl/wb_pkg.sv | 40 ++++
 rtl/load_align.sv | 49 ++++
 rtl/stage_wb_lq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared encodings and width helpers for the writeback stage with load queue.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_NONE = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110,
    F3_RSV = 3'b111
  } funct3_e;

  // Widths for the default configuration (XLEN=32, NREG=32, LQ_DEPTH=4)
  localparam int ADR_W  = 2;
  localparam int RIDX_W = 5;
  localparam int CNT_W  = 3;

  // Derived widths for arbitrary parameter choices
  function automatic int adr_w(input int xlen);
    return $clog2(xlen / 8);
  endfunction

  function automatic int ridx_w(input int nreg);
    return $clog2(nreg);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment: shift the raw word down to the addressed
// byte lane, then sign- or zero-extend according to the load type.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]             rdata,
  input  logic [$clog2(XLEN/8)-1:0]   adr_lo,
  input  logic [2:0]                  funct3,
  output logic [XLEN-1:0]             result
);

  localparam int AW = $clog2(XLEN / 8);

  // Keep the low n bits and replicate bit n-1 upward
  function automatic logic [XLEN-1:0] sext(input logic [XLEN-1:0] v, input int n);
    logic signed [XLEN-1:0] t;
    t = $signed(v << (XLEN - n));
    return t >>> (XLEN - n);
  endfunction

  // Keep the low n bits and clear everything above
  function automatic logic [XLEN-1:0] zext(input logic [XLEN-1:0] v, input int n);
    logic [XLEN-1:0] m;
    m = '1;
    m = m >> (XLEN - n);
    return v & m;
  endfunction

  logic [XLEN-1:0] shifted;

  // Byte-lane shift followed by per-type extension
  always_comb begin
    shifted = rdata >> {adr_lo, 3'b000};
    result  = zext(shifted, 32);
    case (funct3)
      F3_LB:  result = sext(shifted, 8);
      F3_LH:  result = sext(shifted, 16);
      F3_LW:  result = (XLEN == 64) ? sext(shifted, 32) : shifted;
      F3_LD:  result = (XLEN == 64) ? shifted : zext(shifted, 32);
      F3_LBU: result = zext(shifted, 8);
      F3_LHU: result = zext(shifted, 16);
      F3_LWU: result = zext(shifted, 32);
      default: result = zext(shifted, 32);
    endcase
  end

endmodule

// File: rtl/stage_wb_lq.sv
// Writeback stage: immediate retire of ALU/PC+4 results, in-order load queue
// for variable-latency memory responses, and a pending-load scoreboard that
// decode queries for RAW/WAW hazards.
module stage_wb_lq
  import wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 4,
  parameter int NREG     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  in_wb_sel,
  input  logic                        in_reg_write,
  input  logic [$clog2(NREG)-1:0]     in_rd,
  input  logic [2:0]                  in_funct3,
  input  logic [$clog2(XLEN/8)-1:0]   in_adr_lo,
  input  logic [XLEN-1:0]             in_alu_out,
  input  logic [XLEN-1:0]             in_pc_plus4,
  input  logic                        mem_rvalid,
  input  logic [XLEN-1:0]             mem_rdata,
  input  logic [$clog2(NREG)-1:0]     rs1_q,
  input  logic [$clog2(NREG)-1:0]     rs2_q,
  output logic                        rs1_busy,
  output logic                        rs2_busy,
  output logic                        rf_we,
  output logic [$clog2(NREG)-1:0]     rf_waddr,
  output logic [XLEN-1:0]             rf_wdata,
  output logic                        lq_full,
  output logic                        lq_empty,
  output logic                        lq_err
);

  localparam int AW = adr_w(XLEN);
  localparam int RW = ridx_w(NREG);
  localparam int CW = cnt_w(LQ_DEPTH);
  localparam int PW = $clog2(LQ_DEPTH);

  // Queue storage, one field per array
  logic [RW-1:0] q_rd   [LQ_DEPTH];
  logic [2:0]    q_f3   [LQ_DEPTH];
  logic [AW-1:0] q_adr  [LQ_DEPTH];
  logic          q_wen  [LQ_DEPTH];

  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [NREG-1:0] pending;

  logic            is_load, hazard, accept, push, pop, push_wen, alu_wr;
  logic [XLEN-1:0] aligned;

  // Handshake and hazard decode
  always_comb begin
    is_load  = (in_wb_sel == WB_LOAD);
    lq_full  = (count == CW'(LQ_DEPTH));
    lq_empty = (count == '0);
    hazard   = in_reg_write && (in_rd != '0) && pending[in_rd];
    in_ready = !mem_rvalid && !hazard && !(is_load && lq_full);
    accept   = in_valid && in_ready;
    push     = accept && is_load;
    push_wen = in_reg_write && (in_rd != '0);
    pop      = mem_rvalid && !lq_empty;
    alu_wr   = accept && push_wen &&
               ((in_wb_sel == WB_ALU) || (in_wb_sel == WB_PC4));
    rs1_busy = pending[rs1_q] && (rs1_q != '0);
    rs2_busy = pending[rs2_q] && (rs2_q != '0);
  end

  load_align #(.XLEN(XLEN)) u_align (
    .rdata  (mem_rdata),
    .adr_lo (q_adr[head]),
    .funct3 (q_f3[head]),
    .result (aligned)
  );

  // Queue payload write at the tail; payload is don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail]  <= in_rd;
      q_f3[tail]  <= in_funct3;
      q_adr[tail] <= in_adr_lo;
      q_wen[tail] <= push_wen;
    end
  end

  // Queue pointers, occupancy, error flag and pending scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      lq_err  <= 1'b0;
      pending <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (mem_rvalid && lq_empty) lq_err <= 1'b1;
      // Clear first, then set, so a same-cycle push to the same rd wins
      begin
        logic [NREG-1:0] nxt;
        nxt = pending;
        if (pop && q_wen[head]) nxt[q_rd[head]] = 1'b0;
        if (push && push_wen)   nxt[in_rd]      = 1'b1;
        pending <= nxt;
      end
    end
  end

  // Registered register-file write port; load returns take precedence
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pop) begin
      rf_we    <= q_wen[head];
      rf_waddr <= q_rd[head];
      rf_wdata <= aligned;
    end else if (alu_wr) begin
      rf_we    <= 1'b1;
      rf_waddr <= in_rd;
      rf_wdata <= (in_wb_sel == WB_PC4) ? in_pc_plus4 : in_alu_out;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule
